interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources (2..16).
REQ-002 SHALL have parameter VEC_W, default $clog2(N_SRC), vector index width.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_trigger, input, N_SRC, per-source level interrupt request.
REQ-006 SHALL have port i_gie, input, 1, global interrupt enable.
REQ-007 SHALL have port i_mask_we, input, 1, write strobe for the enable mask.
REQ-008 SHALL have port i_mask_wdata, input, N_SRC, new enable mask value.
REQ-009 SHALL have port i_cpu_ack, input, 1, CPU accepts the presented interrupt.
REQ-010 SHALL have port i_eoi, input, 1, CPU end-of-interrupt.
REQ-011 SHALL have port o_irq, output, 1, interrupt request to the CPU.
REQ-012 SHALL have port o_vector, output, VEC_W, index of the presented or in-service source.
REQ-013 SHALL have port o_pending, output, N_SRC, latched pending bits.
REQ-014 SHALL have port o_mask, output, N_SRC, current enable mask.
REQ-015 SHALL have port o_in_service, output, 1, high while a handler is active.

Function
REQ-016 SHALL set pending[k] on any cycle with i_trigger[k]=1 and mask[k]=1; a masked trigger SHALL NOT latch.
REQ-017 SHALL clear pending[k] on the cycle where i_cpu_ack=1 in REQ with o_vector=k; a same-cycle i_trigger[k]=1 with mask[k]=1 SHALL leave pending[k]=1 (set wins).
REQ-018 SHALL clear no latched pending bit when the mask is written; masking SHALL only prevent new latching and selection.
REQ-019 SHALL update the mask one cycle after i_mask_we=1; the new mask SHALL take effect on the following cycle.
REQ-020 SHALL select the lowest-indexed k with pending[k] & mask[k]; index 0 has the highest priority.
REQ-021 SHALL implement an FSM with states IDLE, REQ and SERVICE.
REQ-022 IDLE->REQ on the cycle after i_gie=1 and any pending&mask bit; SHALL register o_vector on that transition.
REQ-023 In REQ, o_irq=1 and o_vector SHALL be held stable even if a higher-priority source becomes pending.
REQ-024 REQ->SERVICE on i_cpu_ack=1; o_irq SHALL drop and o_in_service SHALL rise on the next cycle.
REQ-025 REQ->IDLE with o_irq=0 next cycle if i_gie=0 or the presented source is masked before ack; its pending bit SHALL stay set.
REQ-026 SERVICE->IDLE on i_eoi=1; SERVICE SHALL ignore i_gie, and no new request SHALL be raised during SERVICE (no nesting).
REQ-027 i_eoi outside SERVICE and i_cpu_ack outside REQ SHALL be ignored.
REQ-028 Minimum latency from trigger edge to o_irq=1 SHALL be 2 cycles: 1 cycle to latch pending, 1 cycle for IDLE->REQ.
REQ-029 After EOI, the next request SHALL assert no earlier than 1 cycle in IDLE.

Reset
REQ-030 Asserting i_rst_n=0 SHALL immediately force state=IDLE, pending=0, mask=0, o_irq=0, o_vector=0 and o_in_service=0, regardless of i_clk.
REQ-031 Reset SHALL abort REQ or SERVICE mid-operation, with no pending bit retained.
REQ-032 Release SHALL be synchronised externally; the first active edge after release SHALL behave as IDLE.

Structure
REQ-033 Package argon_int_pkg SHALL hold the default N_SRC, the state enum type int_state_t {IDLE, REQ, SERVICE}, and the vector typedef.
REQ-034 Priority selection SHALL be a combinational sub-module int_priority_enc with inputs req[N_SRC] and outputs valid and idx[VEC_W].

Verification
REQ-035 Scenario 1: mask=0xFF, gie=1, pulse trigger[3] for 1 cycle -> pending[3]=1 next cycle; o_irq=1 and vector=3 the cycle after; ack -> pending[3]=0 and in_service=1; eoi -> IDLE.
REQ-036 Scenario 2: triggers 0x24 simultaneously -> vector=2 first; after ack and eoi, vector=5.
REQ-037 Scenario 3: in REQ with vector=5, trigger[1] arrives -> vector stays 5 until ack; after eoi, vector=1.
REQ-038 Scenario 4: mask=0x00, trigger 0xFF -> pending stays 0 and o_irq stays 0; write mask=0x10 then trigger[4] -> o_irq.
REQ-039 Scenario 5: ack of vector=6 in the same cycle as trigger[6] -> pending[6] stays 1 and is re-presented after eoi.
REQ-040 Scenario 6: assert i_rst_n low mid-SERVICE with pending=0x81 -> all outputs 0 before the next edge; gie=1 after release -> o_irq stays 0.

Source files
------------

// File: rtl/argon_int_pkg.sv
// Shared types and defaults for the argon interrupt controller.
package argon_int_pkg;

  localparam int N_SRC_DEFAULT = 8;
  localparam int VEC_W_DEFAULT = $clog2(N_SRC_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } int_state_t;

  typedef logic [VEC_W_DEFAULT-1:0] int_vec_t;

endpackage

// File: rtl/int_priority_enc.sv
// Combinational fixed-priority encoder: lowest set index wins.
module int_priority_enc #(
  parameter int N_SRC = 8,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [VEC_W-1:0] idx
);

  // Scanning from the top down lets the lowest index overwrite last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req[k]) begin
        valid = 1'b1;
        idx   = VEC_W'(k);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Level-triggered interrupt controller with mask, fixed priority and
// a single non-nesting IDLE/REQ/SERVICE handshake with the CPU.
module interrupt_controller
  import argon_int_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SRC-1:0] i_trigger,
  input  logic             i_gie,
  input  logic             i_mask_we,
  input  logic [N_SRC-1:0] i_mask_wdata,
  input  logic             i_cpu_ack,
  input  logic             i_eoi,
  output logic             o_irq,
  output logic [VEC_W-1:0] o_vector,
  output logic [N_SRC-1:0] o_pending,
  output logic [N_SRC-1:0] o_mask,
  output logic             o_in_service
);

  int_state_t       state;
  int_state_t       state_next;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [VEC_W-1:0] vector;
  logic [N_SRC-1:0] vec_onehot;
  logic [N_SRC-1:0] clr_bits;
  logic             vec_enabled;
  logic             sel_valid;
  logic [VEC_W-1:0] sel_idx;
  logic             load_vec;
  logic             ack_take;

  int_priority_enc #(
    .N_SRC (N_SRC),
    .VEC_W (VEC_W)
  ) u_prio (
    .req   (pending & mask),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  assign vec_onehot  = N_SRC'(1) << vector;
  assign vec_enabled = |(mask & vec_onehot);
  assign clr_bits    = ack_take ? vec_onehot : '0;

  always_comb begin
    state_next = state;
    load_vec   = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (i_gie && sel_valid) begin
          state_next = REQ;
          load_vec   = 1'b1;
        end
      end
      REQ: begin
        // Withdrawal beats acknowledge so a dropped source is never serviced.
        if (!i_gie || !vec_enabled) begin
          state_next = IDLE;
        end else if (i_cpu_ack) begin
          state_next = SERVICE;
          ack_take   = 1'b1;
        end
      end
      SERVICE: begin
        if (i_eoi) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new trigger is OR-ed in after the ack clear, so a same-cycle retrigger survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
      mask    <= '0;
      vector  <= '0;
    end else begin
      pending <= (pending & ~clr_bits) | (i_trigger & mask);
      if (i_mask_we) begin
        mask <= i_mask_wdata;
      end
      if (load_vec) begin
        vector <= sel_idx;
      end
    end
  end

  assign o_irq        = (state == REQ);
  assign o_in_service = (state == SERVICE);
  assign o_vector     = vector;
  assign o_pending    = pending;
  assign o_mask       = mask;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_interrupt_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] trigger;
  logic       gie;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       cpu_ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vector;
  logic [7:0] pending;
  logic [7:0] mask;
  logic       in_service;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pend;
  logic [7:0] m_mask;
  logic       m_irq;
  logic       m_svc;
  int         m_vec;

  interrupt_controller dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_trigger    (trigger),
    .i_gie        (gie),
    .i_mask_we    (mask_we),
    .i_mask_wdata (mask_wdata),
    .i_cpu_ack    (cpu_ack),
    .i_eoi        (eoi),
    .o_irq        (irq),
    .o_vector     (vector),
    .o_pending    (pending),
    .o_mask       (mask),
    .o_in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowest(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_mask = '0;
    m_irq  = 1'b0;
    m_svc  = 1'b0;
    m_vec  = 0;
  endtask

  // One rising edge of the reference: interrupt handshake rules in plain terms.
  task automatic model_step();
    logic [7:0] p;
    int         low;
    if (!rst_n) begin
      model_reset();
      return;
    end
    low = lowest(m_pend & m_mask);
    p   = m_pend;
    if (m_irq) begin
      if (!gie || !m_mask[m_vec]) m_irq = 1'b0;
      else if (cpu_ack) begin
        p[m_vec] = 1'b0;
        m_irq    = 1'b0;
        m_svc    = 1'b1;
      end
    end else if (m_svc) begin
      if (eoi) m_svc = 1'b0;
    end else if (gie && low >= 0) begin
      m_irq = 1'b1;
      m_vec = low;
    end
    p = p | (trigger & m_mask);
    if (mask_we) m_mask = mask_wdata;
    m_pend = p;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    trigger    = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    cpu_ack    = 1'b0;
    eoi        = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] value);
    mask_we    = 1'b1;
    mask_wdata = value;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gie   = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    checks++;
    if ({irq, vector, pending, mask, in_service} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %0h want 0", {irq, vector, pending, mask, in_service});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    write_mask(8'hFF);
    checks++;
    if (mask !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL mask_write got %h want ff", mask);
    end
    gie     = 1'b1;
    trigger = 8'h08;
    tick();
    trigger = '0;
    checks++;
    if ({irq, pending} !== {1'b0, 8'h08}) begin
      errors++;
      $display("[TB] FAIL s1_latch irq=%b pend=%h want irq=0 pend=08", irq, pending);
    end
    tick();
    checks++;
    if ({irq, vector} !== {1'b1, 3'd3}) begin
      errors++;
      $display("[TB] FAIL s1_request irq=%b vec=%0d want 1/3", irq, vector);
    end
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    checks++;
    if ({irq, in_service, pending} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL s1_ack irq=%b svc=%b pend=%h want 0/1/00", irq, in_service, pending);
    end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    checks++;
    if ({irq, in_service} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL s1_eoi irq=%b svc=%b want 0/0", irq, in_service);
    end
  endtask

  task automatic test_priority();
    trigger = 8'h24;
    tick();
    trigger = '0;
    tick();
    checks++;
    if ({irq, vector} !== {1'b1, 3'd2}) begin
      errors++;
      $display("[TB] FAIL s2_first irq=%b vec=%0d want 1/2", irq, vector);
    end
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if ({irq, pending} !== {1'b0, 8'h20}) begin
      errors++;
      $display("[TB] FAIL s2_gap irq=%b pend=%h want 0/20", irq, pending);
    end
    tick();
    checks++;
    if ({irq, vector} !== {1'b1, 3'd5}) begin
      errors++;
      $display("[TB] FAIL s2_second irq=%b vec=%0d want 1/5", irq, vector);
    end
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_hold();
    trigger = 8'h20; tick(); trigger = '0;
    tick();
    trigger = 8'h02; tick(); trigger = '0;
    tick();
    checks++;
    if ({irq, vector, pending} !== {1'b1, 3'd5, 8'h22}) begin
      errors++;
      $display("[TB] FAIL s3_hold irq=%b vec=%0d pend=%h want 1/5/22", irq, vector, pending);
    end
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    checks++;
    if ({irq, vector} !== {1'b1, 3'd1}) begin
      errors++;
      $display("[TB] FAIL s3_next irq=%b vec=%0d want 1/1", irq, vector);
    end
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_masking();
    write_mask(8'h00);
    trigger = 8'hFF; tick(); tick(); trigger = '0;
    checks++;
    if ({irq, pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL s4_masked irq=%b pend=%h want 0/00", irq, pending);
    end
    write_mask(8'h10);
    trigger = 8'h10; tick(); trigger = '0;
    tick();
    checks++;
    if ({irq, vector} !== {1'b1, 3'd4}) begin
      errors++;
      $display("[TB] FAIL s4_unmasked irq=%b vec=%0d want 1/4", irq, vector);
    end
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_ack_retrigger();
    write_mask(8'hFF);
    trigger = 8'h40; tick(); trigger = '0;
    tick();
    cpu_ack = 1'b1;
    trigger = 8'h40;
    tick();
    cpu_ack = 1'b0;
    trigger = '0;
    checks++;
    if ({in_service, pending} !== {1'b1, 8'h40}) begin
      errors++;
      $display("[TB] FAIL s5_set_wins svc=%b pend=%h want 1/40", in_service, pending);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    checks++;
    if ({irq, vector} !== {1'b1, 3'd6}) begin
      errors++;
      $display("[TB] FAIL s5_represent irq=%b vec=%0d want 1/6", irq, vector);
    end
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_abort();
    trigger = 8'h08; tick(); trigger = '0;
    tick();
    gie = 1'b0;
    tick();
    checks++;
    if ({irq, in_service, pending} !== {1'b0, 1'b0, 8'h08}) begin
      errors++;
      $display("[TB] FAIL abort_gie irq=%b svc=%b pend=%h want 0/0/08", irq, in_service, pending);
    end
    gie = 1'b1;
    tick();
    checks++;
    if ({irq, vector} !== {1'b1, 3'd3}) begin
      errors++;
      $display("[TB] FAIL abort_resume irq=%b vec=%0d want 1/3", irq, vector);
    end
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_async_reset();
    trigger = 8'h02; tick(); trigger = '0;
    tick();
    trigger = 8'h81; tick(); trigger = '0;
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    checks++;
    if ({in_service, pending} !== {1'b1, 8'h81}) begin
      errors++;
      $display("[TB] FAIL s6_setup svc=%b pend=%h want 1/81", in_service, pending);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({irq, vector, pending, mask, in_service} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL s6_async got %0h want 0", {irq, vector, pending, mask, in_service});
    end
    tick();
    rst_n = 1'b1;
    gie   = 1'b1;
    tick();
    tick();
    checks++;
    if ({irq, in_service, pending} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL s6_after irq=%b svc=%b pend=%h want 0/0/00", irq, in_service, pending);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      trigger    = 8'($urandom & $urandom & $urandom);
      gie        = ($urandom_range(0, 9) != 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 8'($urandom);
      cpu_ack    = $urandom_range(0, 1) == 1;
      eoi        = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ({irq, vector, pending, mask, in_service} !==
          {m_irq, 3'(m_vec), m_pend, m_mask, m_svc}) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d irq=%b vec=%0d pend=%h mask=%h svc=%b want %b/%0d/%h/%h/%b",
                 i, irq, vector, pending, mask, in_service, m_irq, m_vec, m_pend, m_mask, m_svc);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_hold();
    test_masking();
    test_ack_retrigger();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
